// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between three byte requesters, the arbiter and a UART transmitter.
// The master side drives requests and transmitter status; the arbiter takes the slave side.
interface uart_tx_arbiter_if;
  logic [2:0] i_Req;
  logic [7:0] i_Byte0;
  logic [7:0] i_Byte1;
  logic [7:0] i_Byte2;
  logic [2:0] i_Last;
  logic [2:0] o_Ack;
  logic [2:0] o_Grant;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;
  logic       o_Busy;
  logic       o_Err;

  modport master (
    output i_Req, i_Byte0, i_Byte1, i_Byte2, i_Last, i_Tx_Active, i_Tx_Done,
    input  o_Ack, o_Grant, o_Tx_DV, o_Tx_Byte, o_Busy, o_Err
  );

  modport slave (
    input  i_Req, i_Byte0, i_Byte1, i_Byte2, i_Last, i_Tx_Active, i_Tx_Done,
    output o_Ack, o_Grant, o_Tx_DV, o_Tx_Byte, o_Busy, o_Err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among three byte requesters,
// with frame locking bounded by LOCK_MAX and an activity timeout on each byte.
module uart_tx_arbiter #(
  parameter int LOCK_MAX    = 16,
  parameter int ACT_TIMEOUT = 8
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  uart_tx_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_ACT, WAIT_DONE, GAP} state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_win_q, last_win_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] tout_cnt_q, tout_cnt_d;
  logic       last_flag_q, last_flag_d;

  logic [7:0] req_byte [4];
  logic [3:0] req_pad;
  logic [3:0] last_pad;
  logic [1:0] rr_idx;
  logic [1:0] rr_cand;
  logic       rr_found;
  logic       timeout;
  logic       gap_clear;
  logic       can_continue;

  // Fourth slot pads the 2-bit owner index so every select stays in range.
  assign req_byte[0] = bus.i_Byte0;
  assign req_byte[1] = bus.i_Byte1;
  assign req_byte[2] = bus.i_Byte2;
  assign req_byte[3] = 8'h00;
  assign req_pad     = {1'b0, bus.i_Req};
  assign last_pad    = {1'b0, bus.i_Last};

  // Search starts one past the last winner and wraps 2 -> 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = 2'd0;
    rr_cand  = last_win_q;
    for (int off = 0; off < 3; off++) begin
      rr_cand = (rr_cand == 2'd2) ? 2'd0 : rr_cand + 2'd1;
      if (!rr_found && req_pad[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign timeout      = (tout_cnt_q == 8'(ACT_TIMEOUT - 1));
  assign gap_clear    = !bus.i_Tx_Done && !bus.i_Tx_Active;
  assign can_continue = !last_flag_q && req_pad[owner_q] && (frame_cnt_q < 8'(LOCK_MAX));

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      last_win_q  <= 2'd2;
      tx_byte_q   <= 8'h00;
      frame_cnt_q <= 8'd0;
      tout_cnt_q  <= 8'd0;
      last_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_win_q  <= last_win_d;
      tx_byte_q   <= tx_byte_d;
      frame_cnt_q <= frame_cnt_d;
      tout_cnt_q  <= tout_cnt_d;
      last_flag_q <= last_flag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_win_d  = last_win_q;
    tx_byte_d   = tx_byte_q;
    frame_cnt_d = frame_cnt_q;
    tout_cnt_d  = tout_cnt_q;
    last_flag_d = last_flag_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          owner_d     = rr_idx;
          tx_byte_d   = req_byte[rr_idx];
          frame_cnt_d = 8'd0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        last_flag_d = last_pad[owner_q];
        tx_byte_d   = req_byte[owner_q];
        tout_cnt_d  = 8'd0;
        state_d     = WAIT_ACT;
      end
      WAIT_ACT: begin
        if (bus.i_Tx_Active) begin
          state_d = WAIT_DONE;
        end else if (timeout) begin
          last_win_d = owner_q;
          state_d    = IDLE;
        end else begin
          tout_cnt_d = tout_cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (bus.i_Tx_Done) state_d = GAP;
      end
      GAP: begin
        // Done may linger for several cycles; only a quiet transmitter lets the next byte start.
        if (gap_clear) begin
          if (can_continue) begin
            tx_byte_d = req_byte[owner_q];
            state_d   = LOAD;
          end else begin
            last_win_d = owner_q;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_Grant   = 3'b000;
    bus.o_Ack     = 3'b000;
    bus.o_Tx_DV   = 1'b0;
    bus.o_Busy    = 1'b0;
    bus.o_Err     = 1'b0;
    bus.o_Tx_Byte = tx_byte_q;
    if (state_q != IDLE) begin
      bus.o_Grant = 3'b001 << owner_q;
      bus.o_Busy  = 1'b1;
    end
    if (state_q == LOAD) begin
      bus.o_Tx_DV = 1'b1;
      bus.o_Ack   = 3'b001 << owner_q;
    end
    if (state_q == WAIT_ACT && !bus.i_Tx_Active && timeout) bus.o_Err = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench: queued requesters and a UART transmitter model drive the arbiter,
// and the observed byte order is compared with a queue-level round-robin/frame model.
module tb_uart_tx_arbiter;
  localparam int LOCK = 4;
  localparam int TOUT = 8;
  localparam int QD   = 32;
  localparam int LD   = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.LOCK_MAX(LOCK), .ACT_TIMEOUT(TOUT)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] bmem [3][QD];
  bit         lmem [3][QD];
  int  head [3];
  int  tail [3];
  int  start_at [3];
  bit  pend [3];
  int  cyc = 0;
  int  run_start;

  bit tx_dead, tx_fixed, tx_on;
  int tx_t, tx_a, tx_f, tx_dl;

  int         n_log;
  int         log_owner [LD];
  logic [7:0] log_byte  [LD];
  int         log_cycle [LD];
  int         log_T     [LD];
  int         n_err;
  int         err_cyc   [LD];
  bit         err_busy  [LD];
  bit         err_prev;
  int         viol;

  int         model_last;
  int         n_exp;
  int         exp_owner [LD];
  logic [7:0] exp_byte  [LD];
  bit         exp_cont  [LD];

  task drive_inputs;
    bit act;
    for (int k = 0; k < 3; k++) begin
      act = (head[k] < tail[k]) && ((cyc - run_start) >= start_at[k]);
      bus.i_Req[k]  = act;
      bus.i_Last[k] = act ? lmem[k][head[k]] : 1'b0;
    end
    bus.i_Byte0 = (bus.i_Req[0]) ? bmem[0][head[0]] : 8'h00;
    bus.i_Byte1 = (bus.i_Req[1]) ? bmem[1][head[1]] : 8'h00;
    bus.i_Byte2 = (bus.i_Req[2]) ? bmem[2][head[2]] : 8'h00;
    bus.i_Tx_Active = tx_on && (tx_t >= tx_a) && (tx_t < tx_a + tx_f);
    bus.i_Tx_Done   = tx_on && (tx_t >= tx_a + tx_f);
  endtask

  task clear_bench;
    for (int k = 0; k < 3; k++) begin
      head[k] = 0; tail[k] = 0; start_at[k] = 0; pend[k] = 0;
    end
    n_log = 0; n_err = 0; viol = 0; err_prev = 0; tx_on = 0; tx_t = 0;
    run_start = cyc;
    drive_inputs();
  endtask

  task push(input int k, input logic [7:0] b, input bit l);
    bmem[k][tail[k]] = b;
    lmem[k][tail[k]] = l;
    tail[k]++;
  endtask

  // One clock: observe at the falling edge, then update requesters and transmitter.
  task step;
    int oi;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) if (pend[k]) begin head[k]++; pend[k] = 0; end
    if (err_prev) begin err_busy[n_err-1] = bus.o_Busy; err_prev = 0; end
    if (bus.o_Err) begin err_cyc[n_err] = cyc; n_err++; err_prev = 1; end
    if (bus.o_Ack != 3'b000 && !bus.o_Tx_DV) viol++;
    if (bus.o_Tx_DV) begin
      if (!($onehot(bus.o_Ack) && bus.o_Ack == bus.o_Grant)) viol++;
      case (bus.o_Ack)
        3'b001:  oi = 0;
        3'b010:  oi = 1;
        3'b100:  oi = 2;
        default: oi = -1;
      endcase
      if (oi >= 0) pend[oi] = 1;
      if (tx_fixed) begin
        tx_a = 0; tx_f = 6; tx_dl = 1;
      end else begin
        tx_a = $urandom_range(0, 1); tx_f = $urandom_range(2, 6); tx_dl = $urandom_range(1, 2);
      end
      if (!tx_dead) begin tx_t = 0; tx_on = 1; end
      if (n_log < LD) begin
        log_owner[n_log] = oi; log_byte[n_log] = bus.o_Tx_Byte;
        log_cycle[n_log] = cyc; log_T[n_log] = tx_a + tx_f;
        n_log++;
      end
    end else if (tx_on) begin
      tx_t++;
    end
    if (tx_on && tx_t >= tx_a + tx_f + tx_dl) tx_on = 0;
    drive_inputs();
  endtask

  task run(input int budget, output bit timed_out);
    bit empty;
    run_start = cyc + 1;
    timed_out = 1;
    for (int i = 0; i < budget; i++) begin
      step();
      empty = 1;
      for (int k = 0; k < 3; k++) if (head[k] < tail[k] || pend[k]) empty = 0;
      if (empty && !tx_on && !bus.o_Busy) begin timed_out = 0; break; end
    end
  endtask

  // Frame-level model: pick the next non-empty queue after the last winner, then
  // take bytes until a last flag, LOCK bytes, an empty queue, or (dead tx) one byte.
  task model_predict(input bit dead);
    int h [3];
    int owner, cnt, c;
    bit stop, cont, more;
    n_exp = 0;
    for (int k = 0; k < 3; k++) h[k] = head[k];
    more = 1;
    while (more) begin
      owner = -1;
      for (int off = 1; off <= 3; off++) begin
        c = (model_last + off) % 3;
        if (owner < 0 && h[c] < tail[c]) owner = c;
      end
      if (owner < 0) begin
        more = 0;
      end else begin
        cnt = 0; cont = 0; stop = 0;
        while (!stop) begin
          exp_owner[n_exp] = owner;
          exp_byte[n_exp]  = bmem[owner][h[owner]];
          exp_cont[n_exp]  = cont;
          stop = dead || lmem[owner][h[owner]] || (cnt + 1 >= LOCK);
          h[owner]++; cnt++; n_exp++; cont = 1;
          if (h[owner] >= tail[owner]) stop = 1;
        end
        model_last = owner;
      end
    end
  endtask

  task reset_dut;
    rst = 1;
    clear_bench();
    step(); step();
    rst = 0;
    model_last = 2;
  endtask

  task test_reset;
    rst = 1;
    clear_bench();
    step(); step(); step();
    tests++; if (bus.o_Grant !== 3'b000) begin fails++; $display("FAIL reset_grant: got %b expected 000", bus.o_Grant); end
    tests++; if (bus.o_Ack !== 3'b000) begin fails++; $display("FAIL reset_ack: got %b expected 000", bus.o_Ack); end
    tests++; if (bus.o_Tx_DV !== 1'b0) begin fails++; $display("FAIL reset_dv: got %b expected 0", bus.o_Tx_DV); end
    tests++; if (bus.o_Tx_Byte !== 8'h00) begin fails++; $display("FAIL reset_byte: got %h expected 00", bus.o_Tx_Byte); end
    tests++; if (bus.o_Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.o_Busy); end
    tests++; if (bus.o_Err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", bus.o_Err); end
    rst = 0;
    model_last = 2;
    $display("[TB] test_reset done");
  endtask

  task test_single_byte;
    bit to;
    clear_bench();
    push(0, 8'h55, 1);
    model_predict(0);
    run(200, to);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL single_timeout: run did not go idle"); end
    tests++; if (n_log !== 1) begin fails++; $display("FAIL single_count: got %0d expected 1", n_log); end
    tests++; if (log_owner[0] !== 0 || log_byte[0] !== 8'h55)
      begin fails++; $display("FAIL single_tx: got owner %0d byte %h expected 0 55", log_owner[0], log_byte[0]); end
    tests++; if (log_cycle[0] !== run_start + 1)
      begin fails++; $display("FAIL single_latency: got cycle %0d expected %0d", log_cycle[0], run_start + 1); end
    tests++; if (viol !== 0) begin fails++; $display("FAIL single_ack_rules: got %0d violations expected 0", viol); end
    tests++; if (bus.o_Grant !== 3'b000 || bus.o_Busy !== 1'b0)
      begin fails++; $display("FAIL single_release: got grant %b busy %b expected 000 0", bus.o_Grant, bus.o_Busy); end
    $display("[TB] test_single_byte owner=%0d byte=%h cycle=%0d", log_owner[0], log_byte[0], log_cycle[0]);
  endtask

  task test_fairness;
    bit to;
    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++) push(k, 8'($urandom), 1);
    model_predict(0);
    run(500, to);
    tests++; if (to !== 1'b0 || n_log !== 6)
      begin fails++; $display("FAIL fair_count: got %0d bytes timeout %0d expected 6 0", n_log, to); end
    for (int j = 0; j < 6; j++) begin
      tests++;
      if (log_owner[j] !== j % 3 || log_byte[j] !== exp_byte[j])
        begin fails++; $display("FAIL fair_order[%0d]: got owner %0d byte %h expected %0d %h", j, log_owner[j], log_byte[j], j % 3, exp_byte[j]); end
      $display("[TB] fairness frame %0d owner=%0d byte=%h", j, log_owner[j], log_byte[j]);
    end
  endtask

  task test_frame_lock;
    bit to;
    int         eo [4];
    logic [7:0] eb [4];
    clear_bench();
    push(1, 8'hA0, 0); push(1, 8'hA1, 0); push(1, 8'hA2, 1);
    push(0, 8'h3C, 1);
    start_at[0] = 2;
    eo = '{1, 1, 1, 0};
    eb = '{8'hA0, 8'hA1, 8'hA2, 8'h3C};
    run(500, to);
    model_last = 0;
    tests++; if (to !== 1'b0 || n_log !== 4)
      begin fails++; $display("FAIL lock_count: got %0d bytes timeout %0d expected 4 0", n_log, to); end
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (log_owner[j] !== eo[j] || log_byte[j] !== eb[j])
        begin fails++; $display("FAIL lock_tx[%0d]: got owner %0d byte %h expected %0d %h", j, log_owner[j], log_byte[j], eo[j], eb[j]); end
      $display("[TB] frame_lock byte %0d owner=%0d byte=%h cycle=%0d", j, log_owner[j], log_byte[j], log_cycle[j]);
    end
    for (int j = 1; j < 3; j++) begin
      tests++;
      if (log_cycle[j] - log_cycle[j-1] < log_T[j-1] + 2 || log_cycle[j] - log_cycle[j-1] > log_T[j-1] + 3)
        begin fails++; $display("FAIL lock_spacing[%0d]: got %0d cycles expected %0d..%0d", j, log_cycle[j] - log_cycle[j-1], log_T[j-1] + 2, log_T[j-1] + 3); end
    end
    tests++; if (viol !== 0) begin fails++; $display("FAIL lock_ack_rules: got %0d violations expected 0", viol); end
  endtask

  task test_lock_max;
    bit to;
    clear_bench();
    for (int i = 0; i < 6; i++) push(2, 8'hC0 + 8'(i), 0);
    push(0, 8'h77, 1);
    model_predict(0);
    run(800, to);
    tests++; if (to !== 1'b0 || n_log !== n_exp)
      begin fails++; $display("FAIL lockmax_count: got %0d bytes timeout %0d expected %0d 0", n_log, to, n_exp); end
    for (int j = 0; j < n_exp; j++) begin
      tests++;
      if (log_owner[j] !== exp_owner[j] || log_byte[j] !== exp_byte[j])
        begin fails++; $display("FAIL lockmax_tx[%0d]: got owner %0d byte %h expected %0d %h", j, log_owner[j], log_byte[j], exp_owner[j], exp_byte[j]); end
      $display("[TB] lock_max byte %0d owner=%0d byte=%h", j, log_owner[j], log_byte[j]);
    end
    tests++; if (n_exp !== 7 || exp_owner[4] !== 0 || exp_owner[3] !== 2)
      begin fails++; $display("FAIL lockmax_release: got %0d bytes, 5th owner %0d expected 7 bytes, owner 0", n_exp, exp_owner[4]); end
  endtask

  task test_random;
    bit to;
    int nf, len, bad;
    for (int it = 0; it < 4; it++) begin
      clear_bench();
      for (int k = 0; k < 3; k++) begin
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            push(k, 8'($urandom), (b == len - 1) ? ($urandom_range(0, 3) != 0) : 1'b0);
        end
      end
      if (tail[0] + tail[1] + tail[2] == 0) push(0, 8'($urandom), 1);
      model_predict(0);
      run(3000, to);
      tests++; if (to !== 1'b0 || n_log !== n_exp)
        begin fails++; $display("FAIL rand_count[%0d]: got %0d bytes timeout %0d expected %0d 0", it, n_log, to, n_exp); end
      bad = 0;
      for (int j = 0; j < n_exp; j++) begin
        if (log_owner[j] !== exp_owner[j] || log_byte[j] !== exp_byte[j]) bad++;
        else if (j > 0 && exp_cont[j] &&
                 (log_cycle[j] - log_cycle[j-1] < log_T[j-1] + 2 || log_cycle[j] - log_cycle[j-1] > log_T[j-1] + 3)) bad++;
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL rand_sequence[%0d]: got %0d bad bytes expected 0", it, bad); end
      tests++; if (viol !== 0) begin fails++; $display("FAIL rand_ack_rules[%0d]: got %0d violations expected 0", it, viol); end
      $display("[TB] random run %0d bytes=%0d expected=%0d", it, n_log, n_exp);
    end
  endtask

  task test_timeout;
    bit to;
    clear_bench();
    tx_dead = 1;
    push(1, 8'h11, 1);
    push(2, 8'h21, 0); push(2, 8'h22, 1);
    model_predict(1);
    run(500, to);
    tx_dead = 0;
    tests++; if (to !== 1'b0 || n_log !== n_exp || n_err !== n_exp)
      begin fails++; $display("FAIL tout_count: got %0d bytes %0d errors expected %0d each", n_log, n_err, n_exp); end
    for (int j = 0; j < n_exp; j++) begin
      tests++;
      if (log_owner[j] !== exp_owner[j] || log_byte[j] !== exp_byte[j])
        begin fails++; $display("FAIL tout_tx[%0d]: got owner %0d byte %h expected %0d %h", j, log_owner[j], log_byte[j], exp_owner[j], exp_byte[j]); end
      tests++;
      if (err_cyc[j] - log_cycle[j] !== TOUT || err_busy[j] !== 1'b0)
        begin fails++; $display("FAIL tout_err[%0d]: got delay %0d busy-after %0d expected %0d 0", j, err_cyc[j] - log_cycle[j], err_busy[j], TOUT); end
      if (j > 0) begin
        tests++;
        if (log_cycle[j] !== err_cyc[j-1] + 2)
          begin fails++; $display("FAIL tout_next[%0d]: got cycle %0d expected %0d", j, log_cycle[j], err_cyc[j-1] + 2); end
      end
      $display("[TB] timeout byte %0d owner=%0d err_delay=%0d", j, log_owner[j], err_cyc[j] - log_cycle[j]);
    end
  endtask

  task test_reset_mid_frame;
    bit to, found;
    clear_bench();
    tx_fixed = 1;
    push(2, 8'hE0, 0); push(2, 8'hE1, 0); push(2, 8'hE2, 1);
    run_start = cyc + 1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (n_log >= 1 && tx_on && tx_t == 2) begin found = 1; break; end
    end
    tx_fixed = 0;
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL midreset_reach: got no transfer expected one in flight"); end
    #2 rst = 1;
    #1;
    tests++; if (bus.o_Grant !== 3'b000 || bus.o_Busy !== 1'b0 || bus.o_Tx_Byte !== 8'h00)
      begin fails++; $display("FAIL midreset_async: got grant %b busy %b byte %h expected 000 0 00", bus.o_Grant, bus.o_Busy, bus.o_Tx_Byte); end
    tests++; if (bus.o_Ack !== 3'b000 || bus.o_Tx_DV !== 1'b0 || bus.o_Err !== 1'b0)
      begin fails++; $display("FAIL midreset_strobes: got ack %b dv %b err %b expected 000 0 0", bus.o_Ack, bus.o_Tx_DV, bus.o_Err); end
    clear_bench();
    push(2, 8'hE0, 0);
    step(); step(); step();
    tests++; if (n_log !== 0) begin fails++; $display("FAIL midreset_hold: got %0d strobes in reset expected 0", n_log); end
    clear_bench();
    rst = 0;
    model_last = 2;
    push(0, 8'h0A, 1); push(2, 8'h2A, 1);
    model_predict(0);
    run(300, to);
    tests++; if (to !== 1'b0 || n_log !== 2 || log_owner[0] !== 0 || log_owner[1] !== exp_owner[1])
      begin fails++; $display("FAIL midreset_restart: got %0d bytes first owner %0d expected 2 bytes owner 0", n_log, log_owner[0]); end
    $display("[TB] reset_mid_frame restart owner=%0d byte=%h", log_owner[0], log_byte[0]);
  endtask

  initial begin
    rst = 1; tx_dead = 0; tx_fixed = 0; run_start = 0;
    bus.i_Req = 3'b000; bus.i_Last = 3'b000;
    bus.i_Byte0 = 8'h00; bus.i_Byte1 = 8'h00; bus.i_Byte2 = 8'h00;
    bus.i_Tx_Active = 1'b0; bus.i_Tx_Done = 1'b0;
    test_reset();
    test_single_byte();
    test_fairness();
    test_frame_lock();
    test_lock_max();
    test_random();
    test_timeout();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: LOCK_MAX, default 16, maximum bytes one requester may send per grant before it is forced to release (range 1..255).
REQ-002 Parameter: ACT_TIMEOUT, default 8, cycles to wait for i_Tx_Active after o_Tx_DV before declaring an error (range 2..255).
REQ-003 i_Clock  input  1  clock; all state changes on the rising edge.
REQ-004 i_Reset  input  1  reset, asynchronous, active-high.
REQ-005 i_Req  input  3  per-requester byte request; bit k belongs to requester k.
REQ-006 i_Byte0, i_Byte1, i_Byte2  input  8 each  data byte of requester 0/1/2.
REQ-007 i_Last  input  3  bit k high marks requester k's current byte as the final byte of its frame.
REQ-008 o_Ack  output  3  one-cycle pulse; bit k means requester k's byte was captured.
REQ-009 o_Grant  output  3  one-hot owner of the transmitter; 0 when no owner.
REQ-010 o_Tx_DV  output  1  one-cycle start strobe to the UART transmitter.
REQ-011 o_Tx_Byte  output  8  byte to transmit; stable from o_Tx_DV until the next capture.
REQ-012 i_Tx_Active  input  1  transmitter busy flag.
REQ-013 i_Tx_Done  input  1  transmitter done flag; may stay high for more than one cycle.
REQ-014 o_Busy  output  1  high in every state except IDLE.
REQ-015 o_Err  output  1  one-cycle pulse on activity timeout.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, WAIT_ACT, WAIT_DONE and GAP.
REQ-017 IDLE: if i_Req != 0, select a winner by round-robin, set o_Grant, register the winner's byte into o_Tx_Byte, clear the frame byte count, and go to LOAD; otherwise stay.
REQ-018 Round-robin: search starts at the requester after the last winner (wrapping 2 -> 0); after reset the last winner is 2, so requester 0 has first priority.
REQ-019 LOAD lasts exactly one cycle: o_Tx_DV=1, o_Ack[owner]=1, frame byte count +1, latch i_Last[owner] and the byte, then go to WAIT_ACT.
REQ-020 Requester handshake: the requester holds i_Req, i_Byte and i_Last stable until its o_Ack pulse, and may update them on the cycle after that pulse.
REQ-021 WAIT_ACT: go to WAIT_DONE on i_Tx_Active=1; after ACT_TIMEOUT cycles without it, pulse o_Err, clear o_Grant, record the owner as last winner, and go to IDLE.
REQ-022 WAIT_DONE: go to GAP on i_Tx_Done=1.
REQ-023 GAP: wait until i_Tx_Done=0 and i_Tx_Active=0, then apply the continue rule (REQ-024).
REQ-024 Continue rule: if the latched last flag is 0, i_Req[owner]=1 and frame count < LOCK_MAX, register the owner's new byte and go to LOAD with the grant unchanged.
REQ-025 Otherwise, record the owner as last winner, clear o_Grant, and go to IDLE, where the next arbitration happens one cycle later.
REQ-026 Latency: a request seen in IDLE at edge n produces o_Tx_DV and o_Ack during cycle n+1.
REQ-027 Two consecutive bytes of one frame are separated by the transmitter frame time plus 2..3 cycles; there is no idle gap beyond GAP.
REQ-028 A requester dropping i_Req in mid-frame releases the grant in GAP without error; the partial frame is its own concern.
REQ-029 i_Req rising on other requesters during a frame SHALL NOT pre-empt the owner; it is served at the next IDLE arbitration.
REQ-030 The frame byte counter is 8 bits and SHALL NOT wrap, because LOCK_MAX <= 255 forces release first.
REQ-031 At most one o_Ack bit is high in any cycle, and o_Ack is never high outside LOAD.

Reset
REQ-032 While i_Reset=1, the block SHALL hold: state IDLE; o_Grant=0; o_Ack=0; o_Tx_DV=0; o_Tx_Byte=0x00; o_Busy=0; o_Err=0; last winner=2; frame count=0; timeout count=0.
REQ-033 Reset asserted mid-frame SHALL abort immediately with no further o_Ack or o_Tx_DV; arbitration restarts at requester 0 after release.

Verification
REQ-034 Single byte: i_Req=001, i_Byte0=0x55, i_Last=001 -> next cycle o_Tx_DV=1, o_Tx_Byte=0x55, o_Ack=001; grant released after i_Tx_Done falls; o_Busy=0.
REQ-035 Fairness: i_Req=111 held, every byte last -> owner order 0,1,2,0,1,2 across six frames.
REQ-036 Frame lock: requester 1 sends 0xA0,0xA1,0xA2 (last on 0xA2) while i_Req=011 -> all three bytes transmitted back to back with o_Grant=010 throughout, then requester 0 is served.
REQ-037 LOCK_MAX=4: requester 2 streams 6 bytes with i_Last=0 while requester 0 also requests -> after 4 bytes the grant moves to 0 and requester 2 resumes afterwards.
REQ-038 Timeout: i_Tx_Active tied 0 -> o_Err pulses ACT_TIMEOUT cycles after o_Tx_DV; FSM returns to IDLE; the next requester is served.
REQ-039 Reset during WAIT_DONE of a 3-byte frame -> all outputs take reset values asynchronously; after release with i_Req=101, requester 0 wins first.
